// File: rtl/fetch_stage_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, default widths and flush value.
package fetch_stage_unit_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_PC_STEP = 4;

    localparam int unsigned NOP_INSTR = 0;

endpackage

// File: rtl/fetch_stage_unit_if_id_register.sv
// IF/ID pipeline register: flush beats freeze, freeze beats load; otherwise a bubble is inserted.
module if_id_register
    import fetch_stage_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              freeze,
    input  logic              load,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instr_in,
    output logic [ADDR_W-1:0] pc_id,
    output logic [DATA_W-1:0] instruction_id,
    output logic              valid_id
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_id          <= '0;
            instruction_id <= DATA_W'(NOP_INSTR);
            valid_id       <= 1'b0;
        end else if (flush) begin
            pc_id          <= '0;
            instruction_id <= DATA_W'(NOP_INSTR);
            valid_id       <= 1'b0;
        end else if (freeze) begin
            pc_id          <= pc_id;
            instruction_id <= instruction_id;
            valid_id       <= valid_id;
        end else if (load) begin
            pc_id          <= pc_in;
            instruction_id <= instr_in;
            valid_id       <= 1'b1;
        end else begin
            // Nothing new arrived: decode must not re-execute the previous instruction.
            valid_id <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage_unit.sv
// Fetch stage: PC, req/ack fetch FSM with one-entry hold buffer, and the IF/ID register.
// Optional macro FETCH_STALL_COUNTER_EN adds a saturating stall_count output.
module fetch_stage_unit
    import fetch_stage_unit_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hazard,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_address,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc_id,
    output logic [DATA_W-1:0] instruction_id,
    output logic              valid_id
`ifdef FETCH_STALL_COUNTER_EN
    ,
    output logic [31:0]       stall_count
`endif
);

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] hold_data_reg;
    logic [ADDR_W-1:0] pc_inc;
    logic              ifid_load;
    logic [DATA_W-1:0] ifid_instr;

    assign pc_inc = pc_reg + ADDR_W'(PC_STEP);

    // Request depends only on registered state, never on ack/rdata.
    assign imem_req  = rst_n && (state_reg != HOLD);
    assign imem_addr = addr_reg;

    always_comb begin
        ifid_load  = 1'b0;
        ifid_instr = imem_rdata;
        if (!branch_taken && !hazard) begin
            if (state_reg == FETCH) begin
                ifid_load = imem_ack;
            end else if (state_reg == HOLD) begin
                ifid_load  = 1'b1;
                ifid_instr = hold_data_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= FETCH;
            pc_reg        <= RESET_PC;
            addr_reg      <= RESET_PC;
            hold_data_reg <= DATA_W'(NOP_INSTR);
        end else begin
            case (state_reg)
                FETCH: begin
                    if (branch_taken) begin
                        pc_reg <= branch_address;
                        if (imem_ack) begin
                            addr_reg <= branch_address;
                        end else begin
                            // Outstanding request must finish at its old address; drop its data.
                            state_reg <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        if (hazard) begin
                            hold_data_reg <= imem_rdata;
                            state_reg     <= HOLD;
                        end else begin
                            pc_reg   <= pc_inc;
                            addr_reg <= pc_inc;
                        end
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc_reg        <= branch_address;
                        addr_reg      <= branch_address;
                        hold_data_reg <= DATA_W'(NOP_INSTR);
                        state_reg     <= FETCH;
                    end else if (!hazard) begin
                        pc_reg    <= pc_inc;
                        addr_reg  <= pc_inc;
                        state_reg <= FETCH;
                    end
                end
                DISCARD: begin
                    if (branch_taken) begin
                        pc_reg <= branch_address;
                    end else if (imem_ack) begin
                        addr_reg  <= pc_reg;
                        state_reg <= FETCH;
                    end
                end
                default: begin
                    state_reg <= FETCH;
                end
            endcase
        end
    end

    if_id_register #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (branch_taken),
        .freeze         (hazard),
        .load           (ifid_load),
        .pc_in          (pc_inc),
        .instr_in       (ifid_instr),
        .pc_id          (pc_id),
        .instruction_id (instruction_id),
        .valid_id       (valid_id)
    );

`ifdef FETCH_STALL_COUNTER_EN
    logic [31:0] stall_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
        end else if (!ifid_load && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign stall_count = stall_count_reg;
`endif

endmodule
